vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Timing master for the VGA text/graphics path.
- Divides the system clock down to a pixel-rate enable and runs horizontal and vertical counters.
- Drives hsync and vsync to the connector.
- Supplies pixel_x, pixel_y and video_on to pixel generators such as the font/text renderer. It is the producer end of that pixel-coordinate interface.
- Default timing is 640x480 at 60 Hz from a 50 MHz clk with a 25 MHz pixel enable.

Parameters:
- PIX_DIV, 2: clk cycles per pixel. Legal range 1..16.
- H_DISP, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_DISP, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: hsync active level (0 means active-low).
- V_POL, 0: vsync active level (0 means active-low).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- p_tick  out  1  pixel enable; one clk wide, once every PIX_DIV clks.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when pixel_x < H_DISP and pixel_y < V_DISP.
- hsync  out  1  horizontal sync at polarity H_POL.
- vsync  out  1  vertical sync at polarity V_POL.
- frame_start  out  1  one-clk pulse marking the first clk of position (0,0).

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
  - Both totals must be ≤ 1024; elaboration fails otherwise.
- Reset (reset_n=0 sampled at a clk edge) forces:
  - divider count = 0, p_tick = 0;
  - pixel_x = 0, pixel_y = 0;
  - video_on = 1;
  - hsync = ~H_POL, vsync = ~V_POL (both inactive);
  - frame_start = 0.
  - A reset mid-frame or mid-sync-pulse takes effect on that edge and discards the old position.
- Divider:
  - A counter runs 0..PIX_DIV-1 and wraps.
  - p_tick is registered. It is high in the clk following the cycle where the counter equals PIX_DIV-1.
  - The first p_tick appears PIX_DIV clks after reset release.
  - With PIX_DIV=1, p_tick is high every clk after the first clk following reset release.
- Counters: they advance only in a clk where p_tick=1.
  - pixel_x increments and wraps from H_TOTAL-1 to 0.
  - pixel_y increments only when pixel_x wraps. It wraps from V_TOTAL-1 to 0.
  - When both wrap together, the next position is (0,0).
- Registered decode:
  - video_on, hsync, vsync and frame_start are registered from the next-state counter values.
  - They therefore change on the same clk edge as pixel_x and pixel_y. There is no skew between coordinates and the sync/blank outputs.
- hsync is active while H_DISP+H_FP ≤ pixel_x ≤ H_DISP+H_FP+H_SYNC-1 (656..751).
- vsync is active while V_DISP+V_FP ≤ pixel_y ≤ V_DISP+V_FP+V_SYNC-1 (490..491).
- vsync transitions are aligned to pixel_x=0 of the line.
- frame_start:
  - High for exactly one clk, the first clk in which (pixel_x,pixel_y) reads (0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1).
  - Not asserted after reset.
- Between p_ticks every output holds its value.
- Consumers sample pixel_x, pixel_y and video_on on clk and may use p_tick as their own enable.
- A downstream pipeline of N clks must delay hsync and vsync by N itself; this block adds no delay.
- There is no other input; the counters free-run.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 constants H_DISP..V_BP and the derived H_TOTAL and V_TOTAL;
  - the coordinate width localparam (10);
  - a helper function for the sync-window compare.
- Sub-module pixel_tick_gen holds the PIX_DIV divider plus the registered p_tick, with its own parameter PIX_DIV.
- The counters and decode stay in vga_sync_gen.

Test Plan:
- Reset release, PIX_DIV=2:
  - p_tick first high at clk 2, then every 2 clks;
  - pixel_x reads 0,0,1,1,2…;
  - video_on=1, hsync=vsync=1.
- Run one full line: pixel_x reaches 799 then 0 while pixel_y goes 0→1.
  - hsync low for exactly 96 p_ticks, starting at pixel_x=656.
  - video_on low from pixel_x=640 to 799.
- Run one full frame (800×525 p_ticks = 840000 clks):
  - vsync low exactly on lines 490–491;
  - video_on low for all of lines 480–524;
  - frame_start pulses exactly once, one clk wide, coincident with (0,0);
  - 2nd frame_start at clk 840000 after the 1st.
- Reset asserted at pixel_x=700, pixel_y=491, mid-hsync and mid-vsync:
  - next clk shows 0/0, hsync=vsync=1, video_on=1, p_tick=0;
  - no frame_start is produced.
- PIX_DIV=1, H/V shrunk to 8/2/2/2 and 4/1/1/1:
  - p_tick is constant high after the first clk following reset release;
  - H_TOTAL=14 and V_TOTAL=7 wrap correctly;
  - hsync active at x=10..11, vsync active at y=5.
- H_POL=1, V_POL=1: same windows as the default run with inverted levels; idle hsync and vsync are 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the sync generator and its consumers.
// Defaults describe 640x480 at 60 Hz with a 25 MHz pixel rate.
package vga_timing_pkg;

    // Width of pixel_x / pixel_y; both totals must fit in this many bits.
    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    // 640x480@60 horizontal timing, in pixels.
    localparam int H_DISP = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;

    // 640x480@60 vertical timing, in lines.
    localparam int V_DISP = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    // True when coord lies in the inclusive window [lo, hi]; used for both sync pulses.
    function automatic logic in_window(input coord_t coord, input coord_t lo, input coord_t hi);
        return (coord >= lo) && (coord <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: divides clk by PIX_DIV and emits a registered one-clk p_tick.
// The first p_tick appears PIX_DIV clks after reset release.
module pixel_tick_gen #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int CNT_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_DIV - 1);

    if ((PIX_DIV < 1) || (PIX_DIV > 16)) begin : g_bad_pix_div
        $error("pixel_tick_gen: PIX_DIV must be in 1..16");
    end

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             p_tick_q, p_tick_d;

    // Next divider count and next tick: the tick follows the cycle that holds the last count.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        div_cnt_d = div_cnt_q + CNT_W'(1);
        p_tick_d  = 1'b0;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
            p_tick_d  = 1'b1;
        end
    end

    // Divider state and registered tick, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values, whatever the order.
        if (!reset_n) begin
            div_cnt_q <= '0;
            p_tick_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            p_tick_q  <= p_tick_d;
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel enable, free-running horizontal/vertical counters and
// registered sync/blank/frame outputs that change on the same edge as the coordinates.
module vga_sync_gen #(
    parameter int PIX_DIV = 2,
    parameter int H_DISP  = vga_timing_pkg::H_DISP,
    parameter int H_FP    = vga_timing_pkg::H_FP,
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BP    = vga_timing_pkg::H_BP,
    parameter int V_DISP  = vga_timing_pkg::V_DISP,
    parameter int V_FP    = vga_timing_pkg::V_FP,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BP    = vga_timing_pkg::V_BP,
    parameter int H_POL   = 0,
    parameter int V_POL   = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    output logic                               p_tick,
    output logic [vga_timing_pkg::COORD_W-1:0] pixel_x,
    output logic [vga_timing_pkg::COORD_W-1:0] pixel_y,
    output logic                               video_on,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               frame_start
);

    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::in_window;

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > vga_timing_pkg::MAX_TOTAL) begin : g_bad_h_total
        $error("vga_sync_gen: H_TOTAL exceeds the coordinate range");
    end
    if (V_TOTAL > vga_timing_pkg::MAX_TOTAL) begin : g_bad_v_total
        $error("vga_sync_gen: V_TOTAL exceeds the coordinate range");
    end

    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
    localparam coord_t HS_LO   = coord_t'(H_DISP + H_FP);
    localparam coord_t HS_HI   = coord_t'(H_DISP + H_FP + H_SYNC - 1);
    localparam coord_t VS_LO   = coord_t'(V_DISP + V_FP);
    localparam coord_t VS_HI   = coord_t'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic   H_ACT   = (H_POL != 0);
    localparam logic   V_ACT   = (V_POL != 0);

    coord_t pixel_x_q, pixel_x_d;
    coord_t pixel_y_q, pixel_y_d;
    logic   video_on_q, video_on_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_start_q, frame_start_d;

    pixel_tick_gen #(
        .PIX_DIV (PIX_DIV)
    ) u_pixel_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick)
    );

    // Next position: step x on each tick, carry into y on a line wrap, flag the frame wrap.
    always_comb begin
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        frame_start_d = 1'b0;
        if (p_tick) begin
            if (pixel_x_q == H_LAST) begin
                pixel_x_d = '0;
                if (pixel_y_q == V_LAST) begin
                    pixel_y_d     = '0;
                    frame_start_d = 1'b1;
                end else begin
                    pixel_y_d = pixel_y_q + coord_t'(1);
                end
            end else begin
                pixel_x_d = pixel_x_q + coord_t'(1);
            end
        end
    end

    // Decode blank and sync from the next position so they land on the same edge as x/y.
    always_comb begin
        video_on_d = (int'(pixel_x_d) < H_DISP) && (int'(pixel_y_d) < V_DISP);
        hsync_d    = in_window(pixel_x_d, HS_LO, HS_HI) ? H_ACT : ~H_ACT;
        vsync_d    = in_window(pixel_y_d, VS_LO, VS_HI) ? V_ACT : ~V_ACT;
    end

    // Position and decoded outputs; reset discards the old position immediately.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            video_on_q    <= 1'b1;
            hsync_q       <= ~H_ACT;
            vsync_q       <= ~V_ACT;
            frame_start_q <= 1'b0;
        end else begin
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations (default 640x480, a shrunk 14x7 raster at
// PIX_DIV=1, and a positive-polarity variant) checked every clk against a closed-form model
// of "clks since reset release" through an expected-value queue per instance.
module tb_vga_sync_gen;

    typedef struct {
        int pix_div;
        int hd, hf, hs, hb;
        int vd, vf, vs, vb;
        int hpol, vpol;
    } cfg_t;

    logic       clk = 1'b0;
    logic [2:0] rst_n = 3'b000;

    logic       p_tick [3];
    logic [9:0] px     [3];
    logic [9:0] py     [3];
    logic       von    [3];
    logic       hs     [3];
    logic       vs     [3];
    logic       fs     [3];
    logic [24:0] obs   [3];

    cfg_t cfg [3];
    int   n   [3];
    logic [24:0] exp_q0 [$];
    logic [24:0] exp_q1 [$];
    logic [24:0] exp_q2 [$];

    int vectors     = 0;
    int miscompares = 0;
    int hs_ticks_a    = 0;
    int blank_ticks_a = 0;
    int vs_lines_c    = 0;
    int fs_cnt [3]    = '{0, 0, 0};

    always #5 clk = ~clk;

    vga_sync_gen dut_a (
        .clk(clk), .reset_n(rst_n[0]), .p_tick(p_tick[0]), .pixel_x(px[0]), .pixel_y(py[0]),
        .video_on(von[0]), .hsync(hs[0]), .vsync(vs[0]), .frame_start(fs[0])
    );

    vga_sync_gen #(
        .PIX_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_b (
        .clk(clk), .reset_n(rst_n[1]), .p_tick(p_tick[1]), .pixel_x(px[1]), .pixel_y(py[1]),
        .video_on(von[1]), .hsync(hs[1]), .vsync(vs[1]), .frame_start(fs[1])
    );

    vga_sync_gen #(
        .PIX_DIV(1), .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
    ) dut_c (
        .clk(clk), .reset_n(rst_n[2]), .p_tick(p_tick[2]), .pixel_x(px[2]), .pixel_y(py[2]),
        .video_on(von[2]), .hsync(hs[2]), .vsync(vs[2]), .frame_start(fs[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_obs
        assign obs[g] = {p_tick[g], px[g], py[g], von[g], hs[g], vs[g], fs[g]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Expected outputs n clks after reset release (n=0: still in reset), written as the
    // position index k reached after that many clks rather than as a counter simulation.
    function automatic logic [24:0] model(input cfg_t c, input int clks);
        int   ht, vt, k, x, y;
        logic tick, vo, hact, vact, fst;
        logic [9:0] xv, yv;
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        if (clks == 0) begin
            x = 0; y = 0; tick = 1'b0; fst = 1'b0;
        end else begin
            k    = (clks - 1) / c.pix_div;
            tick = (clks % c.pix_div) == 0;
            x    = k % ht;
            y    = (k / ht) % vt;
            fst  = (k > 0) && (k % (ht * vt) == 0) && ((clks - 1) % c.pix_div == 0);
        end
        vo   = (x < c.hd) && (y < c.vd);
        hact = (x >= c.hd + c.hf) && (x < c.hd + c.hf + c.hs);
        vact = (y >= c.vd + c.vf) && (y < c.vd + c.vf + c.vs);
        xv   = x[9:0];
        yv   = y[9:0];
        return {tick, xv, yv, vo,
                hact ? (c.hpol != 0) : (c.hpol == 0),
                vact ? (c.vpol != 0) : (c.vpol == 0), fst};
    endfunction

    // One clk: push expectations at the edge, pop and compare at the following falling edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) n[i] = rst_n[i] ? n[i] + 1 : 0;
        exp_q0.push_back(model(cfg[0], n[0]));
        exp_q1.push_back(model(cfg[1], n[1]));
        exp_q2.push_back(model(cfg[2], n[2]));
        @(negedge clk);
        check("dut_a outputs", 32'(obs[0]), 32'(exp_q0.pop_front()));
        check("dut_b outputs", 32'(obs[1]), 32'(exp_q1.pop_front()));
        check("dut_c outputs", 32'(obs[2]), 32'(exp_q2.pop_front()));
        if (p_tick[0] && py[0] == 10'd0 && !hs[0])  hs_ticks_a++;
        if (p_tick[0] && py[0] == 10'd0 && !von[0]) blank_ticks_a++;
        if (p_tick[2] && px[2] == 10'd0 && vs[2])   vs_lines_c++;
        for (int i = 0; i < 3; i++) if (fs[i]) fs_cnt[i]++;
    endtask

    initial begin
        bit found;
        cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
        cfg[1] = '{1, 8, 2, 2, 2, 4, 1, 1, 1, 0, 0};
        cfg[2] = '{1, 640, 16, 96, 48, 4, 1, 1, 1, 1, 1};
        n = '{0, 0, 0};

        // Reset held, then free-run: 6000 clks covers 3+ lines of dut_a and a full dut_c frame.
        repeat (3) step();
        rst_n = 3'b111;
        repeat (6000) step();

        check("a_hsync_ticks_line0", 32'(hs_ticks_a), 32'd96);
        check("a_blank_ticks_line0", 32'(blank_ticks_a), 32'd160);
        check("a_frame_starts", 32'(fs_cnt[0]), 32'd0);
        check("b_frame_starts", 32'(fs_cnt[1]), 32'((6000 - 1) / 98));
        check("c_frame_starts", 32'(fs_cnt[2]), 32'd1);
        check("c_vsync_lines", 32'(vs_lines_c), 32'd1);

        // Walk dut_b to x=10, y=5 (inside both sync pulses), then reset it there.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (((n[1] - 1) % 98) == 5 * 14 + 10) found = 1'b1;
            else step();
        end
        check("b_reach_mid_sync", 32'(found), 32'd1);
        check("b_hsync_active", 32'(hs[1]), 32'd0);
        check("b_vsync_active", 32'(vs[1]), 32'd0);
        rst_n[1] = 1'b0;
        fs_cnt[1] = 0;
        repeat (2) step();
        check("b_no_fs_in_reset", 32'(fs_cnt[1]), 32'd0);
        rst_n[1] = 1'b1;
        repeat (300) step();
        check("b_frame_starts_after_reset", 32'(fs_cnt[1]), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
